// File: rtl/l2_request_arbiter_stage.sv
// L2 request arbiter stage: round-robin selection among NUM_PORTS requesters,
// a combinational side-channel to the reservation (LR/SC) logic, and a single
// output register carrying the granted request and its SC-abort result.
module l2_request_arbiter_stage #(
    parameter int NUM_PORTS = 4,
    localparam int unsigned IDW = $clog2(NUM_PORTS)
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic [NUM_PORTS-1:0]          req_valid,
    input  logic [NUM_PORTS-1:0][31:2]    req_addr,
    input  logic [NUM_PORTS-1:0]          req_lr,
    input  logic [NUM_PORTS-1:0]          req_sc,
    input  logic [NUM_PORTS-1:0]          req_store,
    output logic [NUM_PORTS-1:0]          req_ready,

    output logic [31:2]                   res_addr,
    output logic [IDW-1:0]                res_id,
    output logic                          res_strobe,
    output logic                          res_lr,
    output logic                          res_sc,
    output logic                          res_store,
    input  logic                          res_abort,

    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:2]                   out_addr,
    output logic [IDW-1:0]                out_id,
    output logic                          out_lr,
    output logic                          out_sc,
    output logic                          out_store,
    output logic                          out_sc_fail
);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_nxt;
    logic [IDW-1:0] win_id;
    logic [IDW-1:0] cand;
    logic           win_found;
    logic           accept;
    int             sum;

    // Round-robin search: first valid port starting at ptr, wrapping modulo NUM_PORTS.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        sum       = 0;
        cand      = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            sum = int'(ptr) + i;
            if (sum >= NUM_PORTS) begin
                sum = sum - NUM_PORTS;
            end
            cand = IDW'(sum);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    // Accept when something is pending and the output register is free or
    // draining this cycle; reset suppresses any grant.
    always_comb begin
        accept    = win_found & (~out_valid | out_ready) & ~rst;
        req_ready = '0;
        if (accept) begin
            req_ready[win_id] = 1'b1;
        end
    end

    // Winner is presented to the reservation logic in the grant cycle.
    always_comb begin
        res_addr   = req_addr[win_id];
        res_id     = win_id;
        res_lr     = req_lr[win_id];
        res_sc     = req_sc[win_id];
        res_store  = req_store[win_id];
        res_strobe = accept;
    end

    // Pointer moves to the port just after the winner, wrapping at the top.
    always_comb begin
        if (win_id == IDW'(NUM_PORTS - 1)) begin
            ptr_nxt = '0;
        end else begin
            ptr_nxt = win_id + IDW'(1);
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= ptr_nxt;
        end
    end

    // Output register: load on accept (including drain-and-reload), clear on drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_addr    <= '0;
            out_id      <= '0;
            out_lr      <= 1'b0;
            out_sc      <= 1'b0;
            out_store   <= 1'b0;
            out_sc_fail <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_addr    <= req_addr[win_id];
            out_id      <= win_id;
            out_lr      <= req_lr[win_id];
            out_sc      <= req_sc[win_id];
            out_store   <= req_store[win_id];
            out_sc_fail <= req_sc[win_id] & res_abort;
        end else if (out_valid && out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_l2_request_arbiter_stage.sv
// Directed bench for l2_request_arbiter_stage (NUM_PORTS = 4).
module tb_l2_request_arbiter_stage;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       req_valid;
    logic [3:0][31:2] req_addr;
    logic [3:0]       req_lr;
    logic [3:0]       req_sc;
    logic [3:0]       req_store;
    logic [3:0]       req_ready;
    logic [31:2]      res_addr;
    logic [1:0]       res_id;
    logic             res_strobe;
    logic             res_lr;
    logic             res_sc;
    logic             res_store;
    logic             res_abort;
    logic             out_valid;
    logic             out_ready;
    logic [31:2]      out_addr;
    logic [1:0]       out_id;
    logic             out_lr;
    logic             out_sc;
    logic             out_store;
    logic             out_sc_fail;

    int n_tests = 0;
    int n_fail  = 0;

    l2_request_arbiter_stage #(.NUM_PORTS(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_lr(req_lr),
        .req_sc(req_sc), .req_store(req_store), .req_ready(req_ready),
        .res_addr(res_addr), .res_id(res_id), .res_strobe(res_strobe),
        .res_lr(res_lr), .res_sc(res_sc), .res_store(res_store),
        .res_abort(res_abort),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_id(out_id), .out_lr(out_lr), .out_sc(out_sc),
        .out_store(out_store), .out_sc_fail(out_sc_fail)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after input changes.
    task automatic settle();
        #1;
    endtask

    task automatic clear_req();
        req_valid = '0;
        req_lr    = '0;
        req_sc    = '0;
        req_store = '0;
        res_abort = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        clear_req();
        for (int k = 0; k < 4; k++) req_addr[k] = 30'(32'h10 * (k + 1));

        // Reset: nothing granted even with every port requesting.
        req_valid = 4'hF;
        settle();
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_strobe", 32'(res_strobe), 32'h0);
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_addr", 32'(out_addr), 32'h0);
        check("rst_out_id", 32'(out_id), 32'h0);
        check("rst_out_fail", 32'(out_sc_fail), 32'h0);

        // Round robin with all four ports valid: grants 0,1,2,3,0.
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            settle();
            check($sformatf("rr_ready_%0d", c), 32'(req_ready), 32'(4'b0001 << (c % 4)));
            check($sformatf("rr_res_id_%0d", c), 32'(res_id), 32'(c % 4));
            check($sformatf("rr_strobe_%0d", c), 32'(res_strobe), 32'h1);
            tick();
            check($sformatf("rr_out_valid_%0d", c), 32'(out_valid), 32'h1);
            check($sformatf("rr_out_id_%0d", c), 32'(out_id), 32'(c % 4));
            check($sformatf("rr_out_addr_%0d", c), 32'(out_addr), 32'h10 * ((c % 4) + 1));
        end

        // Idle cycle drains the register; ptr now 1.
        clear_req();
        settle();
        check("idle_ready", 32'(req_ready), 32'h0);
        check("idle_strobe", 32'(res_strobe), 32'h0);
        tick();
        check("idle_out_valid", 32'(out_valid), 32'h0);

        // Port 2 LR 0x100 (word 0x40); ptr becomes 3.
        req_valid = 4'b0100; req_lr = 4'b0100; req_addr[2] = 30'h40;
        settle();
        check("lr_ready", 32'(req_ready), 32'h4);
        check("lr_res_lr", 32'(res_lr), 32'h1);
        check("lr_res_addr", 32'(res_addr), 32'h40);
        tick();
        check("lr_out_lr", 32'(out_lr), 32'h1);
        check("lr_out_sc", 32'(out_sc), 32'h0);
        check("lr_out_id", 32'(out_id), 32'h2);

        // Port 2 SC 0x100 with no abort.
        req_lr = '0; req_sc = 4'b0100; res_abort = 1'b0;
        settle();
        check("sc_ok_ready", 32'(req_ready), 32'h4);
        check("sc_ok_res_sc", 32'(res_sc), 32'h1);
        tick();
        check("sc_ok_out_sc", 32'(out_sc), 32'h1);
        check("sc_ok_fail", 32'(out_sc_fail), 32'h0);
        check("sc_ok_addr", 32'(out_addr), 32'h40);

        // ptr = 3, only port 1 valid -> grant 1, ptr becomes 2.
        clear_req();
        req_valid = 4'b0010; req_addr[1] = 30'h55;
        settle();
        check("wrap_ready", 32'(req_ready), 32'h2);
        tick();
        check("wrap_out_id", 32'(out_id), 32'h1);
        check("wrap_out_addr", 32'(out_addr), 32'h55);

        // All valid again: ptr = 2 must pick port 2.
        req_valid = 4'hF;
        settle();
        check("ptr2_ready", 32'(req_ready), 32'h4);
        tick();
        check("ptr2_out_id", 32'(out_id), 32'h2);

        // Port 1 SC 0x200 (word 0x80) aborted by the reservation logic; ptr = 3.
        clear_req();
        req_valid = 4'b0010; req_sc = 4'b0010; req_addr[1] = 30'h80; res_abort = 1'b1;
        settle();
        check("sc_ab_ready", 32'(req_ready), 32'h2);
        check("sc_ab_strobe", 32'(res_strobe), 32'h1);
        tick();
        check("sc_ab_out_sc", 32'(out_sc), 32'h1);
        check("sc_ab_fail", 32'(out_sc_fail), 32'h1);
        check("sc_ab_addr", 32'(out_addr), 32'h80);

        // Strobe stays low once the request is gone, abort still high.
        req_valid = '0; req_sc = '0;
        settle();
        check("sc_ab_strobe_after", 32'(res_strobe), 32'h0);
        tick();
        check("sc_ab_drained", 32'(out_valid), 32'h0);

        // Plain load with abort high never reports an SC failure; ptr = 2 -> port 0.
        req_valid = 4'b0001; req_addr[0] = 30'h77; res_abort = 1'b1;
        settle();
        check("ld_ab_ready", 32'(req_ready), 32'h1);
        tick();
        check("ld_ab_fail", 32'(out_sc_fail), 32'h0);
        check("ld_ab_out_id", 32'(out_id), 32'h0);

        // Drain before backpressure test.
        clear_req();
        tick();
        check("bp_pre_valid", 32'(out_valid), 32'h0);

        // Backpressure: out_ready low for 3 cycles, port 0 valid.
        out_ready = 1'b0;
        req_valid = 4'b0001; req_addr[0] = 30'h33;
        settle();
        check("bp_c1_ready", 32'(req_ready), 32'h1);
        tick();
        check("bp_c1_valid", 32'(out_valid), 32'h1);
        check("bp_c1_addr", 32'(out_addr), 32'h33);
        req_addr[0] = 30'h44; req_store = 4'b0001;
        for (int c = 2; c <= 3; c++) begin
            settle();
            check($sformatf("bp_c%0d_ready", c), 32'(req_ready), 32'h0);
            check($sformatf("bp_c%0d_strobe", c), 32'(res_strobe), 32'h0);
            tick();
            check($sformatf("bp_c%0d_valid", c), 32'(out_valid), 32'h1);
            check($sformatf("bp_c%0d_addr", c), 32'(out_addr), 32'h33);
            check($sformatf("bp_c%0d_store", c), 32'(out_store), 32'h0);
        end
        // Grant resumes in the same cycle out_ready rises.
        out_ready = 1'b1;
        settle();
        check("bp_resume_ready", 32'(req_ready), 32'h1);
        tick();
        check("bp_resume_valid", 32'(out_valid), 32'h1);
        check("bp_resume_addr", 32'(out_addr), 32'h44);
        check("bp_resume_store", 32'(out_store), 32'h1);

        // Reset while holding an entry; ptr was 1, must restart at 0.
        clear_req();
        rst = 1'b1;
        req_valid = 4'hF;
        settle();
        check("rst2_ready", 32'(req_ready), 32'h0);
        check("rst2_strobe", 32'(res_strobe), 32'h0);
        tick();
        check("rst2_out_valid", 32'(out_valid), 32'h0);
        check("rst2_out_addr", 32'(out_addr), 32'h0);
        rst = 1'b0;
        settle();
        check("rst2_restart_ready", 32'(req_ready), 32'h1);
        tick();
        check("rst2_restart_id", 32'(out_id), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
